// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared state, opcode class and error code constants for the uart command parser
package sd_host_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPC  = 2'd1,
    S_ARG  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] OPC_SD   = 2'b00;
  localparam logic [1:0] OPC_HOST = 2'b01;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_OPC  = 3'd1;
  localparam logic [2:0] ERR_CHK  = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_OVR  = 3'd4;
  localparam logic [2:0] ERR_UART = 3'd5;

endpackage

// File: rtl/byte_timeout_timer.sv
// rtl/byte_timeout_timer.sv - saturating inter-byte timer; expired while running at TIMEOUT_CYCLES-1
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic ex_clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge ex_clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - uart byte stream to validated host command frames for sd_fsm
// Optional trailing XOR checksum byte enabled by CMD_CHECKSUM_EN.
module uart_cmd_parser
  import sd_host_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT
) (
  input  logic        ex_clk,
  input  logic        reset,
  input  logic [7:0]  uart_rx_data,
  input  logic [7:0]  uart_ctrl,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic        cmd_is_host,
  output logic [5:0]  uart_cmd,
  output logic [3:0]  host_cmd,
  output logic [31:0] cmd_arg,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy
);

  state_t      state;
  logic [1:0]  arg_cnt;
  logic [6:0]  opc;
  logic [31:0] arg_sh;
  logic [31:0] full_arg;
  logic        rx_valid;
  logic        rx_ferr;
  logic        frame_done;
  logic        handshake;
  logic        expired;
  logic        unused_ctrl;

  assign rx_valid    = uart_ctrl[0];
  assign rx_ferr     = uart_ctrl[1];
  assign unused_ctrl = ^uart_ctrl[7:2];
  assign handshake   = cmd_valid & cmd_ready;
  assign busy        = (state != S_IDLE);
  assign full_arg    = (state == S_ARG) ? {arg_sh[23:0], uart_rx_data} : arg_sh;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] chk;
  assign frame_done = rx_valid && !rx_ferr && state == S_CHK && uart_rx_data == chk;
`else
  assign frame_done = rx_valid && !rx_ferr && state == S_ARG && arg_cnt == 2'd0;
`endif

  byte_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .ex_clk  (ex_clk),
    .reset   (reset),
    .clear   (rx_valid || state == S_IDLE),
    .run     (state != S_IDLE),
    .expired (expired)
  );

  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      arg_cnt     <= '0;
      opc         <= '0;
      arg_sh      <= '0;
`ifdef CMD_CHECKSUM_EN
      chk         <= '0;
`endif
      cmd_valid   <= 1'b0;
      cmd_is_host <= 1'b0;
      uart_cmd    <= '0;
      host_cmd    <= '0;
      cmd_arg     <= '0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      frame_err <= 1'b0;
      if (handshake) cmd_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_ferr) begin
          // A corrupted byte between frames is just line noise, not a frame error.
          if (state != S_IDLE) begin
            state     <= S_IDLE;
            frame_err <= 1'b1;
            err_code  <= ERR_UART;
          end
        end else begin
          case (state)
            S_IDLE: if (uart_rx_data == SOF_BYTE) state <= S_OPC;
            S_OPC: begin
              if (uart_rx_data[7]) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_OPC;
              end else begin
                opc     <= uart_rx_data[6:0];
                arg_cnt <= 2'd3;
                state   <= S_ARG;
`ifdef CMD_CHECKSUM_EN
                chk     <= uart_rx_data;
`endif
              end
            end
            S_ARG: begin
              arg_sh  <= {arg_sh[23:0], uart_rx_data};
              arg_cnt <= arg_cnt - 1'b1;
`ifdef CMD_CHECKSUM_EN
              chk     <= chk ^ uart_rx_data;
              if (arg_cnt == 2'd0) state <= S_CHK;
`else
              if (arg_cnt == 2'd0) state <= S_IDLE;
`endif
            end
            default: begin
              state <= S_IDLE;
`ifdef CMD_CHECKSUM_EN
              if (uart_rx_data != chk) begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
              end
`endif
            end
          endcase

          // The output register holds one command; a completed frame needs it free or freeing now.
          if (frame_done) begin
            if (cmd_valid && !cmd_ready) begin
              frame_err <= 1'b1;
              err_code  <= ERR_OVR;
            end else begin
              cmd_valid   <= 1'b1;
              cmd_is_host <= opc[6];
              uart_cmd    <= opc[6] ? 6'd0 : opc[5:0];
              host_cmd    <= opc[6] ? opc[3:0] : 4'd0;
              cmd_arg     <= full_arg;
            end
          end
        end
      end else if (expired) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed and randomized checks of uart_cmd_parser against a frame-level model
// Checksum frames are exercised when CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_parser;

  localparam int T = 40;

  typedef struct packed {
    logic        is_host;
    logic [5:0]  uc;
    logic [3:0]  hc;
    logic [31:0] arg;
  } cmd_t;

  logic        ex_clk = 1'b0;
  logic        reset;
  logic [7:0]  uart_rx_data;
  logic [7:0]  uart_ctrl;
  logic        cmd_ready;
  logic        cmd_valid;
  logic        cmd_is_host;
  logic [5:0]  uart_cmd;
  logic [3:0]  host_cmd;
  logic [31:0] cmd_arg;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cmd_t       got_cmd[$];
  logic [2:0] got_err[$];
  logic [7:0] fr[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .ex_clk       (ex_clk),
    .reset        (reset),
    .uart_rx_data (uart_rx_data),
    .uart_ctrl    (uart_ctrl),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_is_host  (cmd_is_host),
    .uart_cmd     (uart_cmd),
    .host_cmd     (host_cmd),
    .cmd_arg      (cmd_arg),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 ex_clk = ~ex_clk;

  // Scoreboard capture: commands at handshake, error strobes as they occur.
  always @(negedge ex_clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) got_cmd.push_back({cmd_is_host, uart_cmd, host_cmd, cmd_arg});
      if (frame_err) got_err.push_back(err_code);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ex_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    uart_rx_data = b;
    uart_ctrl    = {6'($urandom), fe, 1'b1};
    tick();
    uart_ctrl    = {6'($urandom), 2'b00};
  endtask

  function automatic cmd_t model_cmd(input logic [7:0] opc, input logic [31:0] arg);
    cmd_t c;
    c.is_host = (opc[7:6] == 2'b01);
    c.uc      = c.is_host ? 6'd0 : opc[5:0];
    c.hc      = c.is_host ? opc[3:0] : 4'd0;
    c.arg     = arg;
    return c;
  endfunction

  task automatic build(input logic [7:0] opc, input logic [31:0] arg);
    logic [7:0] x;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(opc);
    for (int i = 3; i >= 0; i--) fr.push_back(arg[8*i +: 8]);
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
`ifdef CMD_CHECKSUM_EN
    fr.push_back(x);
`endif
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [31:0] arg);
    build(opc, arg);
    foreach (fr[i]) send_byte(fr[i], 1'b0);
  endtask

  task automatic clear_sb();
    got_cmd.delete();
    got_err.delete();
  endtask

  initial begin
    cmd_t       c, x;
    int         n, kind, p;
    bit         ok;
    logic [7:0] opc, g;
    logic [31:0] arg;

    reset = 1'b1;
    uart_rx_data = 8'h00;
    uart_ctrl = 8'h00;
    cmd_ready = 1'b0;
    idle(3);
    chk("reset_outputs", {cmd_valid, frame_err, err_code, busy, cmd_arg},
        {1'b0, 1'b0, 3'd0, 1'b0, 32'd0});
    reset = 1'b0;
    idle(2);

    // Test 1: SD command, ready high, one-cycle latency and single-cycle valid.
    clear_sb();
    cmd_ready = 1'b1;
    send_frame(8'h00, 32'h11223344);
    chk("t1_latency_valid", cmd_valid, 1'b1);
    chk("t1_fields", {cmd_is_host, uart_cmd, cmd_arg}, {1'b0, 6'd0, 32'h11223344});
    tick();
    chk("t1_valid_drop", cmd_valid, 1'b0);
    chk("t1_one_cmd", got_cmd.size(), 1);

    // Test 2: host command held while ready low.
    cmd_ready = 1'b0;
    send_frame(8'h48, 32'h00000001);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok &= (cmd_valid === 1'b1 && cmd_is_host === 1'b1 && host_cmd === 4'd8 &&
             uart_cmd === 6'd0 && cmd_arg === 32'h1);
      tick();
    end
    chk("t2_hold_20", ok, 1'b1);
    cmd_ready = 1'b1;
    tick();
    chk("t2_drop_after_ready", cmd_valid, 1'b0);

    // Test 3: bad opcode, then recovery.
    clear_sb();
    send_byte(8'hA5, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(2);
    chk("t3_err_opc", {got_err.size(), got_cmd.size(), err_code}, {32'd1, 32'd0, 3'd1});
    clear_sb();
    send_frame(8'h05, 32'hCAFEF00D);
    idle(2);
    c = model_cmd(8'h05, 32'hCAFEF00D);
    chk("t3_recover", {got_cmd.size(), got_err.size()}, {32'd1, 32'd0});
    if (got_cmd.size() == 1) chk("t3_recover_cmd", got_cmd[0], c);

    // Test 4: timeout after SOF+OPC, then stray bytes ignored.
    clear_sb();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    n = 0;
    while (!frame_err && n < T + 10) begin
      tick();
      n++;
    end
    chk("t4_timeout_seen", frame_err, 1'b1);
    chk("t4_timeout_window", (n >= T - 1 && n <= T + 1), 1'b1);
    chk("t4_err_busy", {err_code, busy}, {3'd3, 1'b0});
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle(2);
    chk("t4_stray_ignored", {busy, err_code, got_cmd.size(), got_err.size()},
        {1'b0, 3'd3, 32'd0, 32'd1});

    // Test 5: overrun while first command still pending.
    clear_sb();
    cmd_ready = 1'b0;
    send_frame(8'h3F, 32'h01020304);
    send_frame(8'h41, 32'hFFFFFFFF);
    idle(1);
    c = model_cmd(8'h3F, 32'h01020304);
    chk("t5_overrun", {got_err.size(), err_code}, {32'd1, 3'd4});
    chk("t5_held_first", {cmd_valid, cmd_is_host, uart_cmd, host_cmd, cmd_arg}, {1'b1, c});
    cmd_ready = 1'b1;
    idle(2);
    chk("t5_drain", got_cmd.size(), 1);

    // Handshake in the same cycle as completion loads the new frame without error.
    clear_sb();
    cmd_ready = 1'b0;
    send_frame(8'h11, 32'hAAAA5555);
    build(8'h52, 32'h00A5A500);
    for (int i = 0; i < fr.size() - 1; i++) send_byte(fr[i], 1'b0);
    cmd_ready = 1'b1;
    send_byte(fr[fr.size() - 1], 1'b0);
    idle(2);
    chk("same_cycle_counts", {got_cmd.size(), got_err.size()}, {32'd2, 32'd0});
    if (got_cmd.size() == 2) chk("same_cycle_second", got_cmd[1], model_cmd(8'h52, 32'h00A5A500));

    // Framing error: ignored in idle, fatal to a frame in progress.
    clear_sb();
    send_byte(8'hA5, 1'b1);
    idle(1);
    chk("fe_idle_quiet", {busy, got_err.size()}, {1'b0, 32'd0});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    idle(1);
    chk("fe_in_frame", {got_err.size(), err_code, busy}, {32'd1, 3'd5, 1'b0});

`ifdef CMD_CHECKSUM_EN
    clear_sb();
    build(8'h00, 32'h11223344);
    fr[fr.size() - 1] = 8'h00;
    foreach (fr[i]) send_byte(fr[i], 1'b0);
    idle(2);
    chk("chk_wrong", {got_err.size(), got_cmd.size(), err_code}, {32'd1, 32'd0, 3'd2});
`endif

    // Reset asserted mid-frame clears everything.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    reset = 1'b1;
    tick();
    chk("reset_mid_frame", {cmd_valid, frame_err, err_code, busy, cmd_arg, uart_cmd, host_cmd},
        {1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 6'd0, 4'd0});
    reset = 1'b0;
    idle(1);

    // Randomized frames against the frame-level model.
    cmd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      clear_sb();
`ifdef CMD_CHECKSUM_EN
      kind = $urandom_range(0, 4);
`else
      kind = $urandom_range(0, 3);
`endif
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b0);
      end
      opc = 8'($urandom);
      opc[7] = (kind == 1);
      arg = $urandom;
      build(opc, arg);
      p = $urandom_range(1, fr.size() - 1);
      case (kind)
        0: foreach (fr[i]) begin
             send_byte(fr[i], 1'b0);
             idle($urandom_range(0, 3));
           end
        1: begin
             send_byte(fr[0], 1'b0);
             send_byte(fr[1], 1'b0);
           end
        2: begin
             for (int i = 0; i < p; i++) send_byte(fr[i], 1'b0);
             send_byte(fr[p], 1'b1);
           end
        3: begin
             for (int i = 0; i < p; i++) send_byte(fr[i], 1'b0);
             idle(T + 3);
           end
        default: begin
             fr[fr.size() - 1] ^= 8'($urandom_range(1, 255));
             foreach (fr[i]) send_byte(fr[i], 1'b0);
           end
      endcase
      idle(3);
      if (kind == 0) begin
        x = model_cmd(opc, arg);
        chk("rnd_cmd_count", {got_cmd.size(), got_err.size()}, {32'd1, 32'd0});
        if (got_cmd.size() == 1) chk("rnd_cmd", got_cmd[0], x);
      end else begin
        chk("rnd_err_count", {got_cmd.size(), got_err.size()}, {32'd0, 32'd1});
        if (got_err.size() == 1)
          chk("rnd_err_code", got_err[0], (kind == 1) ? 3'd1 : (kind == 2) ? 3'd5 :
                                          (kind == 3) ? 3'd3 : 3'd2);
      end
      chk("rnd_idle_after", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
